// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO, arbitrary depth, full-recirculation capable
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 50
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enq_i,
  input  logic                  deq_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  full_o_n,
  output logic                  empty_o_n
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                  w_do_enq, w_do_deq;
  logic [PW-1:0]         w_wr_nxt, w_rd_nxt;
  assign full_o_n  = r_count != CW'(FIFO_DEPTH);
  assign empty_o_n = r_count != '0;
  assign w_do_enq  = enq_i & (full_o_n | deq_i);
  assign w_do_deq  = deq_i & empty_o_n;
  assign w_wr_nxt  = (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_nxt  = (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
  assign dout_o    = r_mem[r_rd_ptr];
  // pointers and occupancy; reset discards contents logically
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_enq) r_wr_ptr <= w_wr_nxt;
      if (w_do_deq) r_rd_ptr <= w_rd_nxt;
      r_count <= r_count + CW'(w_do_enq) - CW'(w_do_deq);
    end
  end
  // storage array, deliberately unreset
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_do_enq) r_mem[r_wr_ptr] <= din_i;
  end
`ifndef SYNTHESIS
  // occupancy invariants
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(w_do_enq && !w_do_deq && !full_o_n)) else $error("sync_fifo overflow");
      assert (!(w_do_deq && !empty_o_n)) else $error("sync_fifo underflow");
      assert (r_count <= CW'(FIFO_DEPTH)) else $error("sync_fifo count out of range");
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: random and directed checks of sync_fifo against a queue model
module tb_sync_fifo;
  logic clk = 0, rst = 1;
  logic enq5 = 0, deq5 = 0, enq50 = 0, deq50 = 0;
  logic [7:0] din5 = 0, din50 = 0, dout5, dout50;
  logic fn5, en5, fn50, en50;
  logic [7:0] q5[$], q50[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) u5 (
    .clk_i(clk), .rst_i(rst), .enq_i(enq5), .deq_i(deq5), .din_i(din5),
    .dout_o(dout5), .full_o_n(fn5), .empty_o_n(en5));
  sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(50)) u50 (
    .clk_i(clk), .rst_i(rst), .enq_i(enq50), .deq_i(deq50), .din_i(din50),
    .dout_o(dout50), .full_o_n(fn50), .empty_o_n(en50));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    bit de, dq;
    if (rst) begin
      q5.delete();
      q50.delete();
    end else begin
      dq = deq5 && q5.size() > 0;
      de = enq5 && (q5.size() < 5 || deq5);
      if (dq) void'(q5.pop_front());
      if (de) q5.push_back(din5);
      dq = deq50 && q50.size() > 0;
      de = enq50 && (q50.size() < 50 || deq50);
      if (dq) void'(q50.pop_front());
      if (de) q50.push_back(din50);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag);
    chk({tag, "_fn5"}, fn5, q5.size() != 5);
    chk({tag, "_en5"}, en5, q5.size() != 0);
    if (q5.size() > 0) chk({tag, "_dout5"}, dout5, q5[0]);
    chk({tag, "_fn50"}, fn50, q50.size() != 50);
    chk({tag, "_en50"}, en50, q50.size() != 0);
    if (q50.size() > 0) chk({tag, "_dout50"}, dout50, q50[0]);
  endtask
  initial begin
    tick();
    rst = 0;
    tick();
    check("idle");
    chk("idle_en5", en5, 0);
    chk("idle_fn5", fn5, 1);
    enq5 = 1; din5 = 8'h11; rst = 1;
    tick();
    rst = 0; enq5 = 0;
    check("rst_enq");
    chk("rst_enq_en5", en5, 0);
    for (int i = 0; i < 5; i++) begin
      enq5 = 1; din5 = 8'(8'h11 + i);
      tick();
      check("fill5");
      if (i == 0) chk("first_dout5", dout5, 8'h11);
    end
    chk("full5", fn5, 0);
    din5 = 8'hFF;
    tick();
    enq5 = 0;
    check("drop5");
    for (int i = 0; i < 5; i++) begin
      chk("drain_dout5", dout5, 8'(8'h11 + i));
      deq5 = 1;
      tick();
      check("drain5");
    end
    chk("drained_en5", en5, 0);
    tick();
    deq5 = 0;
    check("underflow5");
    chk("underflow_en5", en5, 0);
    for (int i = 0; i < 50; i++) begin
      enq50 = 1; din50 = 8'(i);
      tick();
    end
    enq50 = 0;
    check("fill50");
    chk("full50", fn50, 0);
    for (int i = 0; i < 100; i++) begin
      chk("recirc_dout50", dout50, 8'(i % 50));
      enq50 = 1; deq50 = 1; din50 = dout50;
      tick();
      check("recirc");
    end
    enq50 = 0; deq50 = 0;
    rst = 1;
    tick();
    rst = 0;
    enq50 = 1; deq50 = 1; din50 = 8'hAA;
    tick();
    enq50 = 0; deq50 = 0;
    check("empty_both");
    chk("empty_both_en50", en50, 1);
    chk("empty_both_dout50", dout50, 8'hAA);
    deq50 = 1;
    tick();
    deq50 = 0;
    check("empty_both_pop");
    for (int i = 0; i < 10000; i++) begin
      int pe;
      pe = ((i / 1000) % 2) ? 75 : 25;
      enq5 = $urandom_range(0, 99) < pe;
      deq5 = $urandom_range(0, 99) < 100 - pe;
      din5 = 8'($urandom);
      enq50 = $urandom_range(0, 99) < pe;
      deq50 = $urandom_range(0, 99) < 100 - pe;
      din50 = 8'($urandom);
      rst = $urandom_range(0, 999) == 0;
      tick();
      check("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, first-word-fall-through FIFO with synchronous writes and reads. It serves as the frame buffer inside the wake-word convolution datapath: input samples are enqueued and the head word is continuously presented on `dout_o`. The datapath recirculates a full frame by enqueueing and dequeueing in the same cycle while the FIFO is full. Depth is arbitrary and need not be a power of two (50 in the conv1d use).

## Interface
- `DATA_WIDTH`, default 8: word width in bits.
- `FIFO_DEPTH`, default 50: number of storage entries; must be ≥ 2, any integer.

Ports:
- `clk_i`, input, 1 bit: clock; all state updates on the rising edge.
- `rst_i`, input, 1 bit: reset, synchronous and active-high.
- `enq_i`, input, 1 bit: enqueue request; write `din_i` this cycle.
- `deq_i`, input, 1 bit: dequeue request; pop the head this cycle.
- `din_i`, input, DATA_WIDTH bits: write data.
- `dout_o`, output, DATA_WIDTH bits: current head word (fall-through).
- `full_o_n`, output, 1 bit: 1 = not full (space available).
- `empty_o_n`, output, 1 bit: 1 = not empty (`dout_o` valid).

## Operation
- State:
  - Write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(FIFO_DEPTH) bits.
  - Occupancy `count`, $clog2(FIFO_DEPTH+1) bits.
  - Storage array of FIFO_DEPTH words.
- Flags:
  - `full_o_n = (count != FIFO_DEPTH)`.
  - `empty_o_n = (count != 0)`.
- Effective operations:
  - `do_enq = enq_i & (full_o_n | deq_i)`.
  - `do_deq = deq_i & empty_o_n`.
- `do_enq`: write `din_i` into `mem[wr_ptr]`, then advance `wr_ptr`.
- `do_deq`: advance `rd_ptr`.
- Pointer advance wraps from FIFO_DEPTH-1 to 0 by explicit compare, not by natural binary overflow.
- `count` update: +1 if enq only, -1 if deq only, unchanged if both or neither.
- Full with enq+deq asserted together: the head is popped and `din_i` is written into the freed slot. `count` stays at FIFO_DEPTH. This is the recirculation mode.
- Empty with enq+deq asserted together: the write happens and the dequeue is ignored, so `count` becomes 1. There is no bypass of `din_i` to `dout_o`.
- Enq while full without deq: dropped; no state change.
- Deq while empty: ignored; no state change.
- `dout_o = mem[rd_ptr]`, combinational from the registered array and pointer.
  - `dout_o` is defined only when `empty_o_n = 1`; otherwise its value is don't-care.
- The storage array is not reset.

## Timing
- Reset: on a rising edge with `rst_i = 1`, `wr_ptr`, `rd_ptr` and `count` are cleared to 0. Afterwards `empty_o_n = 0` and `full_o_n = 1`.
- Reset overrides `enq_i`/`deq_i` in the same cycle, including a reset mid-operation; all contents are logically discarded.
- Write-to-read latency: a word enqueued at edge N appears on `dout_o` and raises `empty_o_n` after edge N when the FIFO was empty.
- Flags change only on clock edges; they have no combinational path from `enq_i`/`deq_i`.
- After a `do_deq` at edge N, the next word is on `dout_o` immediately after edge N.
- Throughput: one enq and one deq per cycle, sustained indefinitely.

## Structure
- Single module `sync_fifo`; no submodules.
- No shared package: derive pointer and count widths locally via $clog2.
- Simulation-only assertions under `ifdef`:
  - never overflow;
  - never underflow;
  - `count` ≤ FIFO_DEPTH.

## Test plan
- Reset, then idle: `empty_o_n = 0`, `full_o_n = 1`; assert `rst_i` with `enq_i` held high: still empty afterward.
- FIFO_DEPTH = 5, enqueue 0x11..0x15 on consecutive cycles: `empty_o_n` rises after the first edge with `dout_o = 0x11`; `full_o_n` falls after the 5th edge. A 6th enq of 0xFF is dropped.
- Dequeue all 5 words on consecutive cycles: `dout_o` reads 0x11, 0x12, 0x13, 0x14, 0x15. Then `empty_o_n = 0`, and an extra deq leaves `count` at 0.
- Full FIFO (FIFO_DEPTH = 50, words 0..49), enq+deq for 100 cycles with `din_i = dout_o`:
  - flags stay at full;
  - `dout_o` cycles 0..49 twice;
  - pointers wrap correctly at 49→0.
- Empty FIFO, enq+deq together with 0xAA: `count = 1`, `dout_o = 0xAA`, `empty_o_n = 1`.
- Random enq/deq for 10k cycles against a queue model: `dout_o` matches the model whenever `empty_o_n = 1`; flags match model occupancy every cycle.
